// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: walks the 6502 byte stream through the program counter,
// decodes instruction length and hands whole instructions to execute.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [7:0]  JMP_ABS_OPC  = 8'h4C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic [1:0]  ps,
    output logic [15:0] pc_next,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [7:0]  ins_opcode,
    output logic [15:0] ins_operand,
    output logic [1:0]  ins_len,
    output logic [15:0] ins_pc
);

    localparam logic [1:0] PS_HOLD = 2'd0;
    localparam logic [1:0] PS_INC  = 2'd1;
    localparam logic [1:0] PS_ABS  = 2'd2;

    typedef enum logic [2:0] {
        StRstLo,
        StRstHi,
        StOpc,
        StOp1,
        StOp2,
        StIssue
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic        valid_q, valid_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] ins_pc_q, ins_pc_d;
    logic [1:0]  len_now;
    logic        fetching;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [2:0] bbb;
        logic [1:0] cc;
        bbb = op[4:2];
        cc  = op[1:0];
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) begin
            return 2'd1;
        end
        if (op == 8'h20) begin
            return 2'd3;
        end
        unique case (cc)
            2'b01:   return (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
            2'b11:   return 2'd1;
            default: begin
                unique case (bbb)
                    3'b000, 3'b001, 3'b101: return 2'd2;
                    3'b010, 3'b110:         return 2'd1;
                    3'b011, 3'b111:         return 2'd3;
                    default:                return (cc == 2'b00) ? 2'd2 : 2'd1;
                endcase
            end
        endcase
    endfunction

    assign len_now  = decode_len(mem_data);
    assign fetching = (state_q == StOpc) || (state_q == StOp1) || (state_q == StOp2) ||
                      (state_q == StIssue);

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len_d     = len_q;
        ins_pc_d  = ins_pc_q;
        ps        = PS_HOLD;
        pc_next   = 16'h0000;
        mem_addr  = pc;

        unique case (state_q)
            StRstLo: begin
                mem_addr = RESET_VECTOR;
                lo_d     = mem_data;
                state_d  = StRstHi;
            end
            StRstHi: begin
                mem_addr = RESET_VECTOR + 16'd1;
                ps       = PS_ABS;
                pc_next  = {mem_data, lo_q};
                state_d  = StOpc;
            end
            StOpc: begin
                opcode_d  = mem_data;
                ins_pc_d  = pc;
                len_d     = len_now;
                operand_d = 16'h0000;
                ps        = PS_INC;
                state_d   = (len_now > 2'd1) ? StOp1 : StIssue;
            end
            StOp1: begin
                lo_d      = mem_data;
                operand_d = {8'h00, mem_data};
                ps        = PS_INC;
                state_d   = (len_q == 2'd3) ? StOp2 : StIssue;
            end
            StOp2: begin
                operand_d = {mem_data, lo_q};
                // JMP abs is resolved here so the next opcode comes from the target
                if (opcode_q == JMP_ABS_OPC) begin
                    ps      = PS_ABS;
                    pc_next = {mem_data, lo_q};
                end else begin
                    ps = PS_INC;
                end
                state_d = StIssue;
            end
            StIssue: begin
                if (ins_valid && ins_ready) begin
                    state_d = StOpc;
                end
            end
            default: state_d = StRstLo;
        endcase

        if (redirect_valid && fetching) begin
            ps      = PS_ABS;
            pc_next = redirect_addr;
            state_d = StOpc;
        end

        valid_d = (state_d == StIssue);

        if (!rst) begin
            ps       = PS_HOLD;
            pc_next  = 16'h0000;
            mem_addr = RESET_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StRstLo;
            lo_q      <= 8'h00;
            valid_q   <= 1'b0;
            opcode_q  <= 8'h00;
            operand_q <= 16'h0000;
            len_q     <= 2'd0;
            ins_pc_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len_q     <= len_d;
            ins_pc_q  <= ins_pc_d;
        end
    end

    // A redirect in the issue cycle must block the transfer immediately
    assign ins_valid   = valid_q && !redirect_valid;
    assign ins_opcode  = opcode_q;
    assign ins_operand = operand_q;
    assign ins_len     = len_q;
    assign ins_pc      = ins_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a modelled program counter and memory, directed scenarios,
// then random backpressure/redirects checked against an instruction-level reference.
module tb_fetch_sequencer;

    localparam logic [15:0] RV = 16'hFFFC;
    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] INC  = 2'd1;
    localparam logic [1:0] ABS  = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [1:0]  ps;
    logic [15:0] pc_next;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [7:0]  ins_opcode;
    logic [15:0] ins_operand;
    logic [1:0]  ins_len;
    logic [15:0] ins_pc;

    logic [7:0] mem [65536];

    int vectors = 0;
    int miscompares = 0;

    // Reference state: address of the next instruction execute should receive
    logic [15:0] exp_addr = 16'h0000;
    int          since_rst = 0;
    int          idle = 0;
    logic        prev_rst = 1'b1;
    logic        prev_hold = 1'b0;
    logic [7:0]  held_op;
    logic [15:0] held_operand;
    logic [1:0]  held_len;
    logic [15:0] held_pc;

    localparam logic [1:0] LEN_CC00 [8] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd3};
    localparam logic [1:0] LEN_CC10 [8] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd3};

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .ps             (ps),
        .pc_next        (pc_next),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_opcode     (ins_opcode),
        .ins_operand    (ins_operand),
        .ins_len        (ins_len),
        .ins_pc         (ins_pc)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    // Program counter block
    always @(posedge clk) begin
        case (ps)
            INC:     pc <= pc + 16'd1;
            ABS:     pc <= pc_next;
            default: ;
        endcase
    end

    function automatic logic [1:0] len_of(input logic [7:0] op);
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
        if (op == 8'h20) return 2'd3;
        case (op[1:0])
            2'b01:   return (op[4:2] == 3'd3 || op[4:2] == 3'd6 || op[4:2] == 3'd7) ? 2'd3 : 2'd2;
            2'b00:   return LEN_CC00[op[4:2]];
            2'b10:   return LEN_CC10[op[4:2]];
            default: return 2'd1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0]  op;
        logic [1:0]  len;
        logic [15:0] operand;
        if (prev_hold && prev_rst) begin
            if (!redirect_valid) check("hold_valid", ins_valid, 1);
            check("hold_opcode", ins_opcode, held_op);
            check("hold_operand", ins_operand, held_operand);
            check("hold_len", ins_len, held_len);
            check("hold_pc", ins_pc, held_pc);
        end
        prev_hold = 1'b0;
        if (!rst) begin
            check("rst_ps", ps, HOLD);
            check("rst_pc_next", pc_next, 0);
            check("rst_mem_addr", mem_addr, RV);
            if (!prev_rst) begin
                check("rst_valid", ins_valid, 0);
                check("rst_opcode", ins_opcode, 0);
                check("rst_operand", ins_operand, 0);
                check("rst_len", ins_len, 0);
                check("rst_ins_pc", ins_pc, 0);
            end
            since_rst = 0;
            idle = 0;
        end else begin
            if (since_rst == 0) exp_addr = {mem[RV + 16'd1], mem[RV]};
            if (since_rst >= 2 && redirect_valid) begin
                check("redirect_blocks_valid", ins_valid, 0);
                exp_addr = redirect_addr;
                idle = 0;
            end else if (ins_valid === 1'b1 && ins_ready) begin
                op = mem[exp_addr];
                len = len_of(op);
                operand = 16'h0000;
                if (len > 2'd1) operand[7:0] = mem[exp_addr + 16'd1];
                if (len > 2'd2) operand[15:8] = mem[exp_addr + 16'd2];
                check("ins_opcode", ins_opcode, op);
                check("ins_len", ins_len, len);
                check("ins_operand", ins_operand, operand);
                check("ins_pc", ins_pc, exp_addr);
                exp_addr = (op == 8'h4C) ? operand : exp_addr + 16'(len);
                idle = 0;
            end else begin
                idle++;
                if (idle > 40) begin
                    check("watchdog_progress", idle <= 40, 1);
                    idle = 0;
                end
            end
            if (ins_valid === 1'b1 && !ins_ready) begin
                prev_hold = 1'b1;
                held_op = ins_opcode;
                held_operand = ins_operand;
                held_len = ins_len;
                held_pc = ins_pc;
            end
            since_rst++;
        end
        prev_rst = rst;
    endtask

    task automatic settle();
        #1;
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hEA;
        mem[16'h8001] = 8'hAD; mem[16'h8002] = 8'h34; mem[16'h8003] = 8'h12;
        mem[16'h8004] = 8'h4C; mem[16'h8005] = 8'h00; mem[16'h8006] = 8'h90;
        mem[16'h9000] = 8'hAD;
        mem[16'hA000] = 8'hA9; mem[16'hA001] = 8'h55;
        mem[16'hB000] = 8'hEA;
        @(negedge clk);

        repeat (3) cyc();
        rst = 1'b1;
        settle(); check("rstlo_ps", ps, HOLD); check("rstlo_addr", mem_addr, RV); adv();
        settle(); check("rsthi_ps", ps, ABS); check("rsthi_target", pc_next, 16'h8000);
        check("rsthi_addr", mem_addr, RV + 16'd1); adv();
        settle(); check("opc_addr", mem_addr, 16'h8000); check("opc_ps", ps, INC); adv();
        settle(); check("nop_valid", ins_valid, 1); adv();
        settle(); check("after_nop_addr", mem_addr, 16'h8001); adv();
        cyc(); cyc();
        ins_ready = 1'b0;
        repeat (3) begin
            settle();
            check("bp_valid", ins_valid, 1); check("bp_ps", ps, HOLD);
            check("bp_pc", pc, 16'h8004); check("bp_operand", ins_operand, 16'h1234);
            adv();
        end
        ins_ready = 1'b1;
        settle(); check("bp_accept_valid", ins_valid, 1); adv();
        cyc(); cyc();
        settle(); check("jmp_ps", ps, ABS); check("jmp_target", pc_next, 16'h9000); adv();
        cyc();
        settle(); check("jmp_fetch_addr", mem_addr, 16'h9000); adv();
        redirect_valid = 1'b1; redirect_addr = 16'hA000;
        settle(); check("redir_op1_ps", ps, ABS); check("redir_op1_target", pc_next, 16'hA000);
        adv();
        redirect_valid = 1'b0;
        settle(); check("redir_fetch_addr", mem_addr, 16'hA000); adv();
        cyc();
        redirect_valid = 1'b1; redirect_addr = 16'hB000;
        settle(); check("redir_issue_ps", ps, ABS); adv();
        redirect_valid = 1'b0;
        settle(); check("redir2_fetch_addr", mem_addr, 16'hB000); adv();
        ins_ready = 1'b0;
        settle(); check("pre_rst_valid", ins_valid, 1); adv();
        rst = 1'b0;
        cyc();
        settle(); check("mid_rst_valid", ins_valid, 0); check("mid_rst_addr", mem_addr, RV); adv();

        mem[16'hFFFC] = 8'($urandom);
        mem[16'hFFFD] = 8'($urandom);
        for (int n = 0; n < 4000; n++) begin
            if (rst && $urandom_range(0, 599) == 0) rst = 1'b0;
            else rst = 1'b1;
            ins_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = rst && since_rst >= 2 && $urandom_range(0, 19) == 0;
            redirect_addr = 16'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch front end that drives the program counter block: it issues the ps command (HOLD/INC/ABS) and the pc_in jump target, and consumes pc_out.
- Reads opcode and operand bytes from a combinational-read memory port.
- Decodes 6502 instruction length.
- Loads the reset vector after reset.
- Short-circuits JMP abs.
- Hands complete instructions to execute over a valid/ready handshake.

Parameters:
RESET_VECTOR, 16'hFFFC, address of reset vector low byte (high byte at +1)
JMP_ABS_OPC, 8'h4C, opcode redirected locally via ABS

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
pc  input  addr_t(16)  current PC from program counter pc_out
ps  output  ps_t  command to program counter (HOLD/INC/ABS)
pc_next  output  addr_t(16)  jump target to program counter pc_in, meaningful when ps==ABS
mem_addr  output  16  memory read address
mem_data  input  8  read data for mem_addr, same cycle
redirect_valid  input  1  execute requests PC change (branch/JSR/RTS/etc.)
redirect_addr  input  16  redirect target
ins_valid  output  1  instruction bundle valid
ins_ready  input  1  execute accepts bundle
ins_opcode  output  8  opcode
ins_operand  output  16  {hi,lo}; unused bytes 0
ins_len  output  2  1..3 bytes
ins_pc  output  16  address of opcode

Behaviour:
- Reset is synchronous, active-low, on clk; clock is clk.
- While rst==0:
  - state=RST_LO.
  - ins_valid=0; ins_opcode/operand/len/pc=0.
  - ps=HOLD, pc_next=0, mem_addr=RESET_VECTOR.
- ps, pc_next and mem_addr are combinational from state/inputs. All other outputs are registered.
- Program counter timing: ps applied in cycle N becomes visible on pc in cycle N+1.
- States and transitions:
  - RST_LO: mem_addr=RESET_VECTOR; latch lo=mem_data; ps=HOLD; -> RST_HI.
  - RST_HI: mem_addr=RESET_VECTOR+1; ps=ABS, pc_next={mem_data,lo}; -> OPC.
  - OPC: mem_addr=pc; latch opcode=mem_data, ins_pc=pc; ps=INC; -> OP1 if len>1, else ISSUE.
  - OP1: mem_addr=pc; latch lo; ps=INC; -> OP2 if len==3, else ISSUE.
  - OP2: mem_addr=pc; latch hi.
    - If opcode==JMP_ABS_OPC: ps=ABS, pc_next={mem_data,lo}.
    - Otherwise: ps=INC.
    - Then -> ISSUE.
  - ISSUE: ins_valid=1; ps=HOLD; mem_addr=pc.
    - On ins_valid&&ins_ready: deassert next cycle, -> OPC.
    - Otherwise hold the bundle stable.
- Length decode (opcode = aaa bbb cc):
  - Special cases: 0x00, 0x40, 0x60 -> 1; 0x20 -> 3.
  - cc=01: bbb in {011,110,111} -> 3, else 2.
  - cc=00 or 10, by bbb:
    - bbb=000 -> 2.
    - bbb=001 -> 2.
    - bbb=010 -> 1.
    - bbb=011 -> 3.
    - bbb=100 -> 2 if cc=00, else 1.
    - bbb=101 -> 2.
    - bbb=110 -> 1.
    - bbb=111 -> 3.
  - cc=11 -> 1.
- JMP abs is still issued to execute (len 3) after the ABS redirect. Execute treats it as a no-op.
- redirect_valid in OPC/OP1/OP2/ISSUE:
  - ps=ABS, pc_next=redirect_addr.
  - ins_valid is forced 0 that cycle, so no transfer occurs even if ins_ready=1.
  - The partial instruction is discarded; -> OPC.
- redirect_valid in RST_LO/RST_HI is ignored.
- Redirect has priority over the JMP abs ABS in OP2 and over the handshake.
- Unused operand bytes are zeroed in the bundle.
- rst low mid-operation: returns to RST_LO next edge; any pending bundle is dropped.

Test Plan:
- Reset vector: mem[FFFC]=0x00, mem[FFFD]=0x80, release rst -> ps=HOLD then ABS with pc_next=0x8000; first OPC fetch at mem_addr=0x8000.
- 1-byte: mem[8000]=0xEA, ins_ready=1 -> ins_valid with opcode EA, len 1, operand 0000, ins_pc 8000; next fetch at 8001.
- 3-byte with backpressure: AD 34 12 at 8000, ins_ready=0 for 3 cycles -> bundle AD/1234/len3 held stable, ps=HOLD, pc=8003 throughout; accepted on ready.
- JMP abs: 4C 00 90 at 8000 -> ps=ABS pc_next=9000 in OP2; bundle 4C/9000/len3 issued; next opcode fetched at 9000.
- Redirect mid-fetch: redirect_valid=1, addr=A000 during OP1 of AD -> ps=ABS pc_next=A000, no bundle issued, next fetch at A000. Redirect in ISSUE with ins_ready=1 -> no transfer.
- Reset mid-ISSUE: rst=0 while ins_valid=1 -> ins_valid=0 next cycle, state RST_LO, mem_addr=FFFC.
